// File: rtl/ah_snoop_pkg.sv
// rtl/ah_snoop_pkg.sv - shared states and default widths for the snoop gate and FIFO wrapper
package ah_snoop_pkg;

    localparam int DEF_DATA_W = 110;
    localparam int DEF_KEY_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        BLOCKED = 2'd2,
        PUSH    = 2'd3
    } gate_state_t;

endpackage

// File: rtl/ah_sat_counter.sv
// rtl/ah_sat_counter.sv - saturating up-counter with synchronous active-high clear
module ah_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ah_snoop_enqueue_gate.sv
// rtl/ah_snoop_enqueue_gate.sv - per-key ordering gate in front of the snoopable FIFO
// Optional stall counter output enabled by AH_SNOOP_STALL_CNT_EN.
module ah_snoop_enqueue_gate
    import ah_snoop_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int KEY_W     = DEF_KEY_W,
    parameter int RETRY_GAP = 4,
    parameter int MAX_WAIT  = 256,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] sdata,
    output logic              svalid,
    input  logic              smatch,
`ifdef AH_SNOOP_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic              timeout_err
);

    localparam int GAP_W  = $clog2(RETRY_GAP + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(RETRY_GAP - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    // The FIFO does the key compare; the key width only has to fit inside the word.
    if (KEY_W < 1 || KEY_W > DATA_W || RETRY_GAP < 1 || MAX_WAIT < 1 || CNT_W < 1) begin : g_param_err
        $error("ah_snoop_enqueue_gate: illegal parameter combination");
    end

    gate_state_t        state, state_d;
    logic [DATA_W-1:0]  hold_q;
    logic [GAP_W-1:0]   gap_cnt, gap_d;
    logic [WAIT_W-1:0]  wait_cnt, wait_d;
    logic               load;
    logic               force_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_q      <= '0;
            gap_cnt     <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_d;
            gap_cnt  <= gap_d;
            wait_cnt <= wait_d;
            if (load) begin
                hold_q <= in_data;
            end
            if (force_push) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state;
        gap_d      = gap_cnt;
        wait_d     = wait_cnt;
        load       = 1'b0;
        force_push = 1'b0;
        svalid     = 1'b0;
        wvalid     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                svalid = 1'b1;
                if (smatch) begin
                    state_d = BLOCKED;
                    gap_d   = GAP_RELOAD;
                    wait_d  = WAIT_W'(1);
                end else begin
                    state_d = PUSH;
                end
            end
            BLOCKED: begin
                svalid = (gap_cnt == '0);
                wait_d = wait_cnt + WAIT_W'(1);
                // The wait limit wins even when a re-snoop lands in the same cycle.
                if (wait_cnt >= WAIT_LIMIT) begin
                    force_push = 1'b1;
                    state_d    = PUSH;
                end else if (gap_cnt == '0) begin
                    if (smatch) begin
                        gap_d = GAP_RELOAD;
                    end else begin
                        state_d = PUSH;
                    end
                end else begin
                    gap_d = gap_cnt - GAP_W'(1);
                end
            end
            PUSH: begin
                wvalid = 1'b1;
                if (wready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = CHECK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE) || ((state == PUSH) && wready);
    assign wdata    = hold_q;
    assign sdata    = hold_q;

`ifdef AH_SNOOP_STALL_CNT_EN
    ah_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    ((state == BLOCKED) || ((state == PUSH) && !wready)),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ah_snoop_enqueue_gate.sv
// tb/tb_ah_snoop_enqueue_gate.sv - directed self-checking bench for ah_snoop_enqueue_gate
module tb_ah_snoop_enqueue_gate;

    localparam int DW  = 110;
    localparam int KW  = 32;
    localparam int RG  = 4;
    localparam int MW  = 16;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] sdata;
    logic          svalid;
    logic          smatch;
    logic          timeout_err;
`ifdef AH_SNOOP_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ah_snoop_enqueue_gate #(
        .DATA_W(DW), .KEY_W(KW), .RETRY_GAP(RG), .MAX_WAIT(MW), .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wready     (wready),
        .sdata      (sdata),
        .svalid     (svalid),
        .smatch     (smatch),
`ifdef AH_SNOOP_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .timeout_err(timeout_err)
    );

    function automatic logic [DW-1:0] mk(input logic [31:0] key);
        return (DW'(key) << 64) | DW'(key);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        int wr_cnt;
        int acc;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; wready = 1'b1; smatch = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_wvalid",   128'(wvalid), 128'(0));
        chk("rst_svalid",   128'(svalid), 128'(0));
        chk("rst_wdata",    128'(wdata), 128'(0));
        chk("rst_sdata",    128'(sdata), 128'(0));
        chk("rst_timeout",  128'(timeout_err), 128'(0));
`ifdef AH_SNOOP_STALL_CNT_EN
        chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
`endif

        // Single request, no conflict: accept, check, write.
        rst = 1'b0;
        in_valid = 1'b1; in_data = mk(32'hAA);
        settle();
        chk("t1_c0_in_ready", 128'(in_ready), 128'(1));
        next_cycle();
        in_valid = 1'b0; in_data = '0;
        settle();
        chk("t1_c1_svalid", 128'(svalid), 128'(1));
        chk("t1_c1_sdata",  128'(sdata), 128'(mk(32'hAA)));
        chk("t1_c1_in_ready", 128'(in_ready), 128'(0));
        chk("t1_c1_wvalid", 128'(wvalid), 128'(0));
        next_cycle();
        settle();
        chk("t1_c2_wvalid", 128'(wvalid), 128'(1));
        chk("t1_c2_wdata",  128'(wdata), 128'(mk(32'hAA)));
        chk("t1_c2_in_ready", 128'(in_ready), 128'(1));
        chk("t1_c2_svalid", 128'(svalid), 128'(0));

        // Ten back-to-back requests: one write every two cycles, in order.
        next_cycle();
        wr_cnt = 0; acc = 0;
        for (int c = 0; c <= 20; c++) begin
            in_valid = (acc < 10);
            in_data  = mk(32'h100 + 32'(acc));
            settle();
            if (wvalid && wready) begin
                chk("t2_wdata", 128'(wdata), 128'(mk(32'h100 + 32'(wr_cnt))));
                chk("t2_write_cycle", 128'(c), 128'(2 * wr_cnt + 2));
                wr_cnt++;
            end
            if (in_valid && in_ready) acc++;
            next_cycle();
        end
        in_valid = 1'b0;
        chk("t2_write_count", 128'(wr_cnt), 128'(10));
        chk("t2_accept_count", 128'(acc), 128'(10));

        // Blocked with periodic re-snoop; smatch clears after the third snoop.
        in_valid = 1'b1; in_data = mk(32'h55); smatch = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            smatch = (c <= 9);
            settle();
            chk("t3_svalid", 128'(svalid), 128'((c == 1) || (c == 5) || (c == 9) || (c == 13)));
            chk("t3_in_ready", 128'(in_ready), 128'(0));
            chk("t3_wvalid", 128'(wvalid), 128'(0));
            next_cycle();
        end
        smatch = 1'b0;
        settle();
        chk("t3_push_wvalid", 128'(wvalid), 128'(1));
        chk("t3_push_wdata", 128'(wdata), 128'(mk(32'h55)));
        chk("t3_timeout", 128'(timeout_err), 128'(0));
        next_cycle();

        // Permanent match: forced push after MAX_WAIT blocked cycles.
        in_valid = 1'b1; in_data = mk(32'h77); smatch = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            settle();
            chk("t4_wvalid_blocked", 128'(wvalid), 128'(0));
            chk("t4_timeout_early", 128'(timeout_err), 128'(0));
            next_cycle();
        end
        settle();
        chk("t4_forced_wvalid", 128'(wvalid), 128'(1));
        chk("t4_forced_wdata", 128'(wdata), 128'(mk(32'h77)));
        chk("t4_timeout_set", 128'(timeout_err), 128'(1));
        smatch = 1'b0;
        for (int c = 0; c < 3; c++) next_cycle();
        settle();
        chk("t4_timeout_sticky", 128'(timeout_err), 128'(1));
        chk("t4_idle_in_ready", 128'(in_ready), 128'(1));
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        settle();
        chk("t4_timeout_cleared", 128'(timeout_err), 128'(0));

        // FIFO full for five cycles while pushing.
        in_valid = 1'b1; in_data = mk(32'h99);
        next_cycle();
        in_data = mk(32'h123);
        wready = 1'b0;
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("t5_wvalid", 128'(wvalid), 128'(1));
            chk("t5_wdata", 128'(wdata), 128'(mk(32'h99)));
            chk("t5_in_ready", 128'(in_ready), 128'(0));
            next_cycle();
        end
        wready = 1'b1; in_valid = 1'b0;
        settle();
        chk("t5_release_wvalid", 128'(wvalid), 128'(1));
        chk("t5_release_wdata", 128'(wdata), 128'(mk(32'h99)));
        chk("t5_release_in_ready", 128'(in_ready), 128'(1));
`ifdef AH_SNOOP_STALL_CNT_EN
        chk("t5_stall_cnt", 128'(stall_cnt), 128'(5));
`endif
        next_cycle();

        // Reset while blocked discards the held request.
        in_valid = 1'b1; in_data = mk(32'hBB); smatch = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; smatch = 1'b0;
        settle();
        chk("t6_in_ready", 128'(in_ready), 128'(1));
        chk("t6_svalid", 128'(svalid), 128'(0));
        chk("t6_wvalid", 128'(wvalid), 128'(0));
        chk("t6_wdata", 128'(wdata), 128'(0));
        wr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            settle();
            if (wvalid) wr_cnt++;
        end
        chk("t6_no_write", 128'(wr_cnt), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
